// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor code width, floor limits and the
// request-encoder FSM state constants. floor_code_t is shared with the display decoders.
package elevator_pkg;

   localparam int FLOOR_CODE_W = 3;
   localparam int MAX_FLOORS   = 8;

   typedef logic [FLOOR_CODE_W-1:0] floor_code_t;

   typedef logic [0:0] fsm_state_t;
   localparam fsm_state_t IDLE  = 1'b0;
   localparam fsm_state_t OFFER = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// One call button: two-flop synchronizer, debounce counter and debounced level.
// Emits a single-cycle press pulse on the same edge the debounced level rises.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             settle;

   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      // The edge that sees the last of DEBOUNCE_CYCLES mismatches flips deb
      settle  = (sync2_q != deb_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
      if (sync2_q != deb_q) begin
         if (settle) deb_d = sync2_q;
         else        cnt_d = cnt_q + 1'b1;
      end
      press = settle && sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/floor_request_encoder.sv
// Debounced call buttons -> pending requests -> one floor code at a time on valid/ack.
// Define REQ_ROUND_ROBIN_EN for circular selection after the last grant; default is lowest floor first.
module floor_request_encoder
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS      = 7,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] btn,
   input  logic                  req_ack,
   output logic                  req_valid,
   output floor_code_t           req_floor,
   output logic [NUM_FLOORS-1:0] pending
);

   logic [NUM_FLOORS-1:0] press;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   fsm_state_t            state_q, state_d;
   floor_code_t           req_floor_q, req_floor_d;
   floor_code_t           sel_floor;

   for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst_n(rst_n),
         .btn  (btn[g]),
         .press(press[g])
      );
   end

`ifdef REQ_ROUND_ROBIN_EN
   floor_code_t rr_q, rr_d;
   floor_code_t sel_lo, sel_hi;
   logic        hi_found;

   // Lowest pending at or above the pointer, else wrap to lowest pending overall
   always_comb begin
      sel_lo   = '0;
      sel_hi   = '0;
      hi_found = 1'b0;
      for (int j = NUM_FLOORS - 1; j >= 0; j--) begin
         if (pending_q[j]) begin
            sel_lo = floor_code_t'(j);
            if (floor_code_t'(j) >= rr_q) begin
               sel_hi   = floor_code_t'(j);
               hi_found = 1'b1;
            end
         end
      end
      sel_floor = hi_found ? sel_hi : sel_lo;
   end
`else
   always_comb begin
      sel_floor = '0;
      for (int j = NUM_FLOORS - 1; j >= 0; j--) begin
         if (pending_q[j]) sel_floor = floor_code_t'(j);
      end
   end
`endif

   always_comb begin
      pending_d   = pending_q | press;
      state_d     = state_q;
      req_floor_d = req_floor_q;
`ifdef REQ_ROUND_ROBIN_EN
      rr_d        = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|pending_q) begin
               state_d     = OFFER;
               req_floor_d = sel_floor;
            end
         end
         default: begin
            if (req_ack) begin
               // Clear after the OR so a same-edge press of this floor is dropped
               for (int i = 0; i < NUM_FLOORS; i++) begin
                  if (floor_code_t'(i) == req_floor_q) pending_d[i] = 1'b0;
               end
               state_d = IDLE;
`ifdef REQ_ROUND_ROBIN_EN
               rr_d = (req_floor_q == floor_code_t'(NUM_FLOORS - 1)) ? '0
                                                                     : req_floor_q + 1'b1;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= '0;
         state_q     <= IDLE;
         req_floor_q <= '0;
`ifdef REQ_ROUND_ROBIN_EN
         rr_q        <= '0;
`endif
      end else begin
         pending_q   <= pending_d;
         state_q     <= state_d;
         req_floor_q <= req_floor_d;
`ifdef REQ_ROUND_ROBIN_EN
         rr_q        <= rr_d;
`endif
      end
   end

   assign req_valid = (state_q == OFFER);
   assign req_floor = req_floor_q;
   assign pending   = pending_q;

endmodule

// File: tb/tb_floor_request_encoder.sv
// Directed bench for floor_request_encoder (NUM_FLOORS=7, DEBOUNCE_CYCLES=4) with a
// windowed behavioural model compared every cycle, plus literal expectations.
module tb_floor_request_encoder;

   localparam int N = 7;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn = '0;
   logic         req_ack = 1'b0;
   logic         req_valid;
   logic [2:0]   req_floor;
   logic [N-1:0] pending;

   int total = 0;
   int bad   = 0;

   floor_request_encoder #(
      .NUM_FLOORS     (N),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn      (btn),
      .req_ack  (req_ack),
      .req_valid(req_valid),
      .req_floor(req_floor),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: a level is accepted once the last D synchronized samples all disagree with it
   logic [N-1:0] m_pend, m_deb, s1, s2;
   logic [D-1:0] hist [N];
   int           hcnt [N];
   bit           m_offer;
   int           m_floor, m_rr;
   int           m_grants[$];
   int           d_grants[$];
   bit           prev_valid;
   int           prev_floor;
   bit           auto_ack = 1'b0;

   function automatic int pick(input logic [N-1:0] p, input int rr);
`ifdef REQ_ROUND_ROBIN_EN
      for (int i = 0; i < N; i++) if (p[(rr + i) % N]) return (rr + i) % N;
`else
      for (int i = 0; i < N; i++) if (p[i]) return i;
`endif
      return rr * 0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_deb = '0; s1 = '0; s2 = '0;
      for (int n = 0; n < N; n++) begin hist[n] = '0; hcnt[n] = 0; end
      m_offer = 1'b0; m_floor = 0; m_rr = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] press;
      logic [N-1:0] pend_pre;
      press    = '0;
      pend_pre = m_pend;
      for (int n = 0; n < N; n++) begin
         hist[n] = {hist[n][D-2:0], s2[n]};
         if (hcnt[n] < D) hcnt[n]++;
         if (hcnt[n] == D && hist[n] == {D{~m_deb[n]}}) begin
            m_deb[n] = ~m_deb[n];
            press[n] = m_deb[n];
         end
      end
      s2 = s1;
      s1 = btn;
      m_pend = m_pend | press;
      if (m_offer) begin
         if (req_ack) begin
            m_pend[m_floor] = 1'b0;
            m_offer = 1'b0;
            m_rr = (m_floor + 1) % N;
            m_grants.push_back(m_floor);
         end
      end else if (pend_pre != '0) begin
         m_floor = pick(pend_pre, m_rr);
         m_offer = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else begin
            if (prev_valid && req_ack) d_grants.push_back(prev_floor);
            model_step();
         end
         #1;
         chk("cyc_valid", int'(req_valid), int'(m_offer));
         chk("cyc_pending", int'(pending), int'(m_pend));
         if (m_offer) chk("cyc_floor", int'(req_floor), m_floor);
         prev_valid = req_valid;
         prev_floor = int'(req_floor);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (auto_ack) req_ack = req_valid;
      end
   endtask

   initial begin
      // Reset with random button levels
      rst_n = 1'b0;
      btn = N'($urandom);
      tick(3);
      chk("rst_valid", int'(req_valid), 0);
      chk("rst_floor", int'(req_floor), 0);
      chk("rst_pending", int'(pending), 0);
      btn = '0;
      rst_n = 1'b1;
      tick(10);
      chk("post_rst_valid", int'(req_valid), 0);

      // Single press on floor 3; this negedge follows edge 0
      btn[3] = 1'b1;
      tick(6);
      chk("sp_pending_e6", int'(pending), 8);
      chk("sp_valid_e6", int'(req_valid), 0);
      tick(1);
      chk("sp_valid_e7", int'(req_valid), 1);
      chk("sp_floor_e7", int'(req_floor), 3);
      tick(1);
      req_ack = 1'b1;
      tick(1);
      req_ack = 1'b0;
      chk("sp_valid_e9", int'(req_valid), 0);
      chk("sp_pending_e9", int'(pending), 0);
      tick(3);
      btn[3] = 1'b0;
      tick(12);
      chk("sp_no_second", int'(req_valid), 0);
      chk("sp_no_second_pend", int'(pending), 0);

      // Glitch of 3 cycles on floor 2
      btn[2] = 1'b1;
      tick(3);
      btn[2] = 1'b0;
      tick(12);
      chk("gl_pending", int'(pending), 0);
      chk("gl_valid", int'(req_valid), 0);

      // Simultaneous presses on floors 1 and 5, acked on every offer
      m_grants.delete();
      d_grants.delete();
      auto_ack = 1'b1;
      btn = 7'b0100010;
      tick(14);
      btn = '0;
      tick(10);
      auto_ack = 1'b0;
      req_ack = 1'b0;
      chk("sim_ngrants", d_grants.size(), 2);
      chk("sim_model_ngrants", m_grants.size(), 2);
`ifdef REQ_ROUND_ROBIN_EN
      if (d_grants.size() == 2) begin
         chk("sim_first", d_grants[0], 5);
         chk("sim_second", d_grants[1], 1);
      end
      if (m_grants.size() == 2) chk("sim_model_first", m_grants[0], 5);
`else
      if (d_grants.size() == 2) begin
         chk("sim_first", d_grants[0], 1);
         chk("sim_second", d_grants[1], 5);
      end
      if (m_grants.size() == 2) chk("sim_model_first", m_grants[0], 1);
`endif

      // Stalled ack with a new press during OFFER
      btn[4] = 1'b1;
      tick(8);
      chk("st_valid", int'(req_valid), 1);
      chk("st_floor", int'(req_floor), 4);
      btn[4] = 1'b0;
      btn[0] = 1'b1;
      tick(20);
      chk("st_floor_held", int'(req_floor), 4);
      chk("st_pending", int'(pending), 17);
      req_ack = 1'b1;
      tick(1);
      req_ack = 1'b0;
      btn[0] = 1'b0;
      chk("st_valid_after_ack", int'(req_valid), 0);
      chk("st_pending_after_ack", int'(pending), 1);
      tick(1);
      chk("st_next_valid", int'(req_valid), 1);
      chk("st_next_floor", int'(req_floor), 0);
      req_ack = 1'b1;
      tick(1);
      req_ack = 1'b0;
      chk("st_pending_clear", int'(pending), 0);
      tick(10);

      // Asynchronous reset during OFFER
      btn[6] = 1'b1;
      tick(8);
      chk("ro_valid", int'(req_valid), 1);
      chk("ro_floor", int'(req_floor), 6);
      btn[6] = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("ro_async_valid", int'(req_valid), 0);
      chk("ro_async_pending", int'(pending), 0);
      tick(2);
      rst_n = 1'b1;
      tick(10);
      chk("ro_after_valid", int'(req_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
